// File: rtl/wave_pkg.sv
// Shared types for the waveform sequencing controller: opcodes, waveform
// select, controller states and default widths.
package wave_pkg;

  localparam int unsigned PHASE_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF  = 8;

  typedef enum logic [1:0] {
    OP_SET_TW   = 2'd0,
    OP_SET_WAVE = 2'd1,
    OP_SET_STEP = 2'd2,
    OP_SWEEP_TO = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_SWEEP = 2'd3
  } state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: register plus adder with enable, clear and carry-out.
// carry is the combinational carry of the pending add; wrap is its registered copy.
module phase_acc #(
  parameter int unsigned W = 24,
  parameter int unsigned A = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] inc,
  output logic [A-1:0] addr,
  output logic         carry,
  output logic         wrap
);

  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = en & sum[W];
  assign addr  = acc[W-1 -: A];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      acc  <= sum[W-1:0];
      wrap <= sum[W];
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_ctrl.sv
// Waveform sequencing controller: command staging, wrap-aligned frequency and
// waveform changes, and stepped linear frequency sweeps.
module wave_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [PHASE_W-1:0] cmd_data,
  output logic [ADDR_W-1:0]  phase_addr,
  output logic [1:0]         wave_sel,
  output logic               wrap,
  output logic               busy,
  output logic [PHASE_W-1:0] tw_active
);

  state_e             state, state_n;
  wave_e              wave_reg, wave_n;
  cmd_op_e            op, stg_op, stg_op_n;
  logic [PHASE_W-1:0] tw_n, step_reg, step_n, sweep_end, end_n;
  logic [PHASE_W-1:0] stg_data, stg_data_n, sweep_tw;
  logic               sweeping, sweeping_n, accept, carry, acc_en, acc_clr;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state != ST_PEND);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = sweeping;
  assign wave_sel  = wave_reg;
  assign acc_en    = (state != ST_IDLE);

  phase_acc #(
    .W(PHASE_W),
    .A(ADDR_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_en),
    .clr  (acc_clr),
    .inc  (tw_active),
    .addr (phase_addr),
    .carry(carry),
    .wrap (wrap)
  );

  // Next sweep tuning word; compares distances first so the step never overshoots or wraps.
  always_comb begin
    sweep_tw = sweep_end;
    if (sweep_end > tw_active) begin
      if (sweep_end - tw_active > step_reg) sweep_tw = tw_active + step_reg;
    end else if (sweep_end < tw_active) begin
      if (tw_active - sweep_end > step_reg) sweep_tw = tw_active - step_reg;
    end
  end

  always_comb begin
    state_n    = state;
    tw_n       = tw_active;
    wave_n     = wave_reg;
    step_n     = step_reg;
    end_n      = sweep_end;
    sweeping_n = sweeping;
    stg_op_n   = stg_op;
    stg_data_n = stg_data;
    acc_clr    = 1'b0;

    if (accept && op == OP_SET_STEP) step_n = cmd_data;

    case (state)
      ST_IDLE: begin
        if (accept && op == OP_SET_TW) begin
          tw_n = cmd_data;
          if (cmd_data != '0) state_n = ST_RUN;
        end else if (accept && op == OP_SET_WAVE) begin
          wave_n = wave_e'(cmd_data[1:0]);
        end
      end
      ST_RUN: begin
        if (accept && (op == OP_SET_TW || op == OP_SET_WAVE)) begin
          stg_op_n   = op;
          stg_data_n = cmd_data;
          state_n    = ST_PEND;
        end else if (accept && op == OP_SWEEP_TO) begin
          if (step_reg != '0 && cmd_data != tw_active) begin
            sweeping_n = 1'b1;
            end_n      = cmd_data;
            state_n    = ST_SWEEP;
          end
        end
      end
      ST_SWEEP: begin
        if (carry) begin
          tw_n = sweep_tw;
          if (sweep_tw == sweep_end) begin
            sweeping_n = 1'b0;
            state_n    = ST_RUN;
          end
        end
        if (accept && op != OP_SET_STEP) begin
          stg_op_n   = op;
          stg_data_n = cmd_data;
          state_n    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (carry) begin
          // A running sweep still steps on this wrap unless the staged command overrides it.
          if (sweeping) begin
            tw_n = sweep_tw;
            if (sweep_tw == sweep_end) sweeping_n = 1'b0;
          end
          case (stg_op)
            OP_SET_TW: begin
              tw_n       = stg_data;
              sweeping_n = 1'b0;
              if (stg_data == '0) begin
                state_n = ST_IDLE;
                acc_clr = 1'b1;
              end else begin
                state_n = ST_RUN;
              end
            end
            OP_SWEEP_TO: begin
              tw_n = tw_active;
              if (step_reg != '0 && stg_data != tw_active) begin
                sweeping_n = 1'b1;
                end_n      = stg_data;
                state_n    = ST_SWEEP;
              end else begin
                sweeping_n = 1'b0;
                state_n    = ST_RUN;
              end
            end
            default: begin
              if (stg_op == OP_SET_WAVE) wave_n = wave_e'(stg_data[1:0]);
              state_n = sweeping_n ? ST_SWEEP : ST_RUN;
            end
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tw_active <= '0;
      wave_reg  <= WAVE_SINE;
      step_reg  <= '0;
      sweep_end <= '0;
      sweeping  <= 1'b0;
      stg_op    <= OP_SET_TW;
      stg_data  <= '0;
    end else begin
      state     <= state_n;
      tw_active <= tw_n;
      wave_reg  <= wave_n;
      step_reg  <= step_n;
      sweep_end <= end_n;
      sweeping  <= sweeping_n;
      stg_op    <= stg_op_n;
      stg_data  <= stg_data_n;
    end
  end

endmodule

// File: tb/tb_wave_ctrl.sv
// Bench for wave_ctrl: directed scenarios plus random commands, every output
// compared each cycle against a behavioural model of the command rules.
module tb_wave_ctrl;

  localparam int unsigned PW  = 24;
  localparam int unsigned AW  = 8;
  localparam longint      MOD = 64'd1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [PW-1:0] cmd_data = '0;
  logic [AW-1:0] phase_addr;
  logic [1:0]    wave_sel;
  logic          wrap;
  logic          busy;
  logic [PW-1:0] tw_active;

  wave_ctrl #(
    .PHASE_W(PW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .phase_addr(phase_addr),
    .wave_sel  (wave_sel),
    .wrap      (wrap),
    .busy      (busy),
    .tw_active (tw_active)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint m_acc, m_tw, m_step, m_end, p_data;
  int     m_wave, p_op;
  bit     m_wrap, m_busy, m_run, m_pend;

  function automatic void model_reset();
    m_acc = 0; m_tw = 0; m_step = 0; m_end = 0; p_data = 0;
    m_wave = 0; p_op = 0;
    m_wrap = 0; m_busy = 0; m_run = 0; m_pend = 0;
  endfunction

  function automatic void sweep_step();
    if (m_end > m_tw) m_tw = (m_tw + m_step > m_end) ? m_end : m_tw + m_step;
    else              m_tw = (m_tw - m_step < m_end) ? m_end : m_tw - m_step;
    if (m_tw == m_end) m_busy = 0;
  endfunction

  function automatic void model_edge();
    bit     accept, old_busy, old_run, old_pend, carry;
    longint d;
    int     op;
    if (rst) begin
      model_reset();
      return;
    end
    accept   = cmd_valid && !m_pend;
    old_pend = m_pend;
    old_busy = m_busy;
    old_run  = m_run;
    op       = int'(cmd_op);
    d        = longint'(cmd_data);
    carry    = m_run && (m_acc + m_tw >= MOD);
    if (m_run) m_acc = (m_acc + m_tw) % MOD;
    m_wrap = carry;
    if (carry) begin
      if (old_pend) begin
        m_pend = 0;
        case (p_op)
          0: begin
            m_tw   = p_data;
            m_busy = 0;
            if (p_data == 0) begin
              m_run = 0; m_acc = 0; m_wrap = 0;
            end
          end
          1: begin
            m_wave = int'(p_data & 3);
            if (m_busy) sweep_step();
          end
          default: begin
            if (m_step != 0 && p_data != m_tw) begin
              m_busy = 1; m_end = p_data;
            end else begin
              m_busy = 0;
            end
          end
        endcase
      end else if (old_busy) begin
        sweep_step();
      end
    end
    if (accept) begin
      if (op == 2) begin
        m_step = d;
      end else if (!old_run) begin
        if (op == 0) begin
          m_tw = d; m_run = (d != 0);
        end else if (op == 1) begin
          m_wave = int'(d & 3);
        end
      end else if (!old_busy && op == 3) begin
        if (m_step != 0 && d != m_tw) begin
          m_busy = 1; m_end = d;
        end
      end else begin
        m_pend = 1; p_op = op; p_data = d;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("phase_addr", 64'(phase_addr), 64'((m_acc >> (PW - AW)) & ((64'd1 << AW) - 1)));
    check_eq("wave_sel", 64'(wave_sel), 64'(m_wave));
    check_eq("wrap", 64'(wrap), 64'(m_wrap));
    check_eq("busy", 64'(busy), 64'(m_busy));
    check_eq("tw_active", 64'(tw_active), 64'(m_tw));
    check_eq("cmd_ready", 64'(cmd_ready), 64'(!m_pend));
  endtask

  task automatic send(input int op, input longint data);
    bit done;
    int n;
    done = 0;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_data  = PW'(data);
    while (!done) begin
      done = (cmd_ready === 1'b1);
      tick();
      n++;
      if (!done && n > 5000) begin
        check_eq("send_timeout", 64'(cmd_ready), 64'd1);
        done = 1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wrap(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (wrap !== 1'b1 && n < budget);
    check_eq("wrap_seen", 64'(wrap), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();

    // Reset defaults and quiet IDLE
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_tw", 64'(tw_active), 64'd0);
    check_eq("rst_addr", 64'(phase_addr), 64'd0);
    repeat (100) tick();

    // Start from IDLE
    send(0, 64'h010000);
    check_eq("start_tw", 64'(tw_active), 64'h010000);
    check_eq("start_addr_hold", 64'(phase_addr), 64'd0);
    tick();
    check_eq("start_addr_first", 64'(phase_addr), 64'd1);
    wait_wrap(600);
    n = 0;
    do begin tick(); n++; end while (wrap !== 1'b1 && n < 600);
    check_eq("period_256", 64'(n), 64'd256);

    // Staged frequency change at address 0x40
    for (int i = 0; i < 600 && phase_addr != 8'h40; i++) tick();
    check_eq("addr_reach_40", 64'(phase_addr), 64'h40);
    send(0, 64'h020000);
    check_eq("stage_ready_low", 64'(cmd_ready), 64'd0);
    check_eq("stage_tw_old", 64'(tw_active), 64'h010000);
    wait_wrap(600);
    check_eq("stage_tw_new", 64'(tw_active), 64'h020000);
    check_eq("stage_ready_back", 64'(cmd_ready), 64'd1);
    n = 0;
    do begin tick(); n++; end while (wrap !== 1'b1 && n < 600);
    check_eq("period_128", 64'(n), 64'd128);

    // Waveform change only at a wrap
    send(1, 64'd2);
    check_eq("wave_hold", 64'(wave_sel), 64'd0);
    wait_wrap(600);
    check_eq("wave_applied", 64'(wave_sel), 64'd2);

    // Upward sweep with clamp
    send(0, 64'h010000);
    wait_wrap(600);
    send(2, 64'h018000);
    send(3, 64'h040000);
    check_eq("sweep_busy", 64'(busy), 64'd1);
    wait_wrap(1000);
    check_eq("sweep_up_1", 64'(tw_active), 64'h028000);
    check_eq("sweep_up_busy", 64'(busy), 64'd1);
    wait_wrap(1000);
    check_eq("sweep_up_2", 64'(tw_active), 64'h040000);
    check_eq("sweep_up_done", 64'(busy), 64'd0);

    // Downward sweep clamps at the end value
    send(2, 64'h010000);
    send(3, 64'h008000);
    for (int i = 0; i < 5000 && busy !== 1'b0; i++) tick();
    check_eq("sweep_down_end", 64'(tw_active), 64'h008000);

    // Zero step never raises busy
    send(2, 64'd0);
    send(3, 64'h100000);
    check_eq("step0_busy", 64'(busy), 64'd0);

    // SET_TW 0 back to IDLE, then SWEEP_TO ignored there
    send(0, 64'd0);
    for (int i = 0; i < 2000 && tw_active !== '0; i++) tick();
    check_eq("idle_tw", 64'(tw_active), 64'd0);
    send(2, 64'h010000);
    send(3, 64'h100000);
    repeat (20) tick();
    check_eq("idle_sweep_busy", 64'(busy), 64'd0);
    check_eq("idle_sweep_addr", 64'(phase_addr), 64'd0);

    // Command accepted on the edge that carries waits for the next wrap
    send(0, 64'h030000);
    for (int i = 0; i < 200 && !(m_acc + m_tw >= MOD); i++) tick();
    send(1, 64'd3);
    check_eq("wrapcmd_hold", 64'(wave_sel), 64'd2);
    wait_wrap(200);
    check_eq("wrapcmd_applied", 64'(wave_sel), 64'd3);

    // Reset during a sweep with a staged waveform change
    send(2, 64'h000100);
    send(3, 64'hF00000);
    repeat (20) tick();
    send(1, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_wave", 64'(wave_sel), 64'd0);
    check_eq("mid_rst_tw", 64'(tw_active), 64'd0);
    check_eq("mid_rst_ready", 64'(cmd_ready), 64'd1);
    repeat (1000) tick();
    check_eq("post_rst_wave", 64'(wave_sel), 64'd0);

    // Random commands against the model
    for (int i = 0; i < 6000; i++) begin
      rst       = ($urandom_range(0, 799) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cmd_data = '0;
      else cmd_data = PW'($urandom_range(32'h004000, 32'h100000));
      tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
